vga_frame_layers: RTL and testbench
===================================

# vga_frame_layers

Parametrised successor of the maze frame renderer. It composites a block-based maze background, N sprite channels with colour-key transparency and per-sprite blinking, and a bottom progress bar into 12-bit RGB. Output latency is fixed and parameterised. The block sits between the VGA timing generator and the VGA pins. All ROMs are external, so the same block serves every level and sprite set.

## Interface
Parameters:
- BLOCK_SHIFT, 4, log2 of block side in pixels; sprite ROMs are (1<<BLOCK_SHIFT)² words
- N_SPRITES, 2, sprite channels; channel 0 has highest priority
- MAZE_COLS, 64, maze ROM row stride in blocks
- MAZE_ROWS, 29, maze rows drawn; rows ≥ MAZE_ROWS other than BAR_BROW render black
- BAR_BROW, 29, block row holding the progress bar
- ROM_LAT, 1, read latency of every external ROM in cycles (1..3)
- BLINK_FRAMES, 30, frames per blink half-period (≥2)
- KEY_COLOR, 12'hF0F, sprite RGB treated as transparent

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- i_pix_valid  in  1  current pixel is in the visible area
- i_col, i_row  in  10 each  current pixel coordinates
- i_frame_start  in  1  one-cycle pulse, once per frame
- i_spr_bcol, i_spr_brow  in  6*N_SPRITES each  sprite block positions, channel k at [6k+5:6k]
- i_spr_en  in  N_SPRITES  sprite shown
- i_spr_blink  in  N_SPRITES  sprite subject to blinking
- i_bar_level  in  6  filled bar blocks
- o_maze_en  out  1, o_maze_addr  out  $clog2(MAZE_COLS*MAZE_ROWS), i_maze_data  in  16  maze ROM port
- o_spr_en  out  N_SPRITES, o_spr_addr  out  2*BLOCK_SHIFT*N_SPRITES, i_spr_data  in  16*N_SPRITES  sprite ROM ports
- o_pix_valid  out  1  pixel valid, aligned with RGB
- o_red, o_green, o_blue  out  4 each  pixel colour

## Operation
- Stage 0 (combinational on inputs): bcol=i_col>>BLOCK_SHIFT, brow=i_row>>BLOCK_SHIFT; lc=i_col[BLOCK_SHIFT-1:0], lr likewise.
- Tag classes: NOTHING (i_pix_valid=0), BAR (brow==BAR_BROW), BLACK (brow≥MAZE_ROWS, not bar), LAYER (otherwise).
- LAYER: o_maze_en=1, o_maze_addr=brow*MAZE_COLS+bcol.
- LAYER, sprite k visible iff i_spr_en[k], position match, and not (i_spr_blink[k] && blink_phase). Lowest visible k is the hit: o_spr_en[k]=1, addr=lr*(1<<BLOCK_SHIFT)+lc. All other enables are 0.
- The tag, hit index, hit flag, and bcol shift through a ROM_LAT-deep register pipeline alongside the ROM reads.
- Compose when the tag exits the pipeline:
  - BAR: F00 if delayed bcol < i_bar_level, else 314. i_bar_level ≥ 40 gives a fully red bar.
  - BLACK/NOTHING: 000.
  - LAYER with hit: sprite data[15:4] unless it equals KEY_COLOR, in which case maze data[15:4]. No fall-through to a lower-priority sprite.
  - LAYER without hit: maze data[15:4].
- The composed colour is registered into o_red/o_green/o_blue. o_pix_valid is the registered tag≠NOTHING.
- Blink counter, width $clog2(BLINK_FRAMES), increments on i_frame_start. When it reaches BLINK_FRAMES-1, it wraps to 0 on the next pulse and toggles blink_phase.

## Timing
- Latency from i_col/i_row/i_pix_valid to o_* is exactly ROM_LAT+1 cycles, for every tag class.
- ROM enables and addresses are combinational from the current inputs and are presented in the same cycle.
- i_spr_* and i_bar_level are sampled at stage 0 and at compose respectively, so the bar uses the level at output time.
- blink_phase change takes effect on the pixel sampled in the cycle after the wrapping i_frame_start. The pixel sampled with the pulse uses the old phase.
- During reset: o_red/o_green/o_blue=0, o_pix_valid=0, all pipeline tags=NOTHING, blink counter=0, blink_phase=0, ROM enables=0.
- After reset release, outputs stay 0 for ROM_LAT+1 cycles. Reset mid-frame discards all in-flight pixels.
- Two sprites on the same block: lower index wins. A transparent pixel of the winner shows the maze.

## Test plan
- ROM_LAT=1, sprite0 at (3,2), pixel (col 50,row 37), sprite ROM word 0x7A5x -> o_spr_en[0]=1, addr 5*16+2=82; RGB 7A5 with o_pix_valid=1 two cycles later.
- Sprite0 word 0xF0Fx over maze word 0x123x at the same block -> RGB 123. Sprites 0 and 1 at the same block -> only o_spr_en[0] asserted.
- Row 470 (block 29), i_bar_level=5: col 79 -> F00, col 80 -> 314. i_bar_level=63 -> all F00.
- BLINK_FRAMES=2, i_spr_blink[0]=1: after the 2nd i_frame_start, sprite0 is hidden (maze shown, o_spr_en[0]=0); after the 4th it is visible again.
- ROM_LAT=3: a valid-pixel burst emerges exactly 4 cycles later with matching colours. Assert rst=0 mid-burst -> outputs 0 that cycle onward, no stale pixel after release.
- i_pix_valid=0 -> all enables 0, RGB 000, o_pix_valid=0 after latency.

Source files
------------

// File: rtl/vga_frame_layers_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_frame_layers_if : ROM bus between the layer compositor and its ROMs
// Revision 1.0
// ----------------------------------------------------------------------
interface vga_frame_layers_if #(
   parameter int N_SPRITES   = 2,
   parameter int BLOCK_SHIFT = 4,
   parameter int MAZE_AW     = 11
);
   logic                               o_maze_en;
   logic [MAZE_AW-1:0]                 o_maze_addr;
   logic [15:0]                        i_maze_data;
   logic [N_SPRITES-1:0]               o_spr_en;
   logic [2*BLOCK_SHIFT*N_SPRITES-1:0] o_spr_addr;
   logic [16*N_SPRITES-1:0]            i_spr_data;

   modport master (
      output o_maze_en, o_maze_addr, o_spr_en, o_spr_addr,
      input  i_maze_data, i_spr_data
   );
   modport slave (
      input  o_maze_en, o_maze_addr, o_spr_en, o_spr_addr,
      output i_maze_data, i_spr_data
   );
endinterface
`default_nettype wire

// File: rtl/vga_frame_layers.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_frame_layers : maze + prioritised sprites + progress bar to 12-bit RGB
// Revision 1.0
// ----------------------------------------------------------------------
module vga_frame_layers #(
   parameter int          BLOCK_SHIFT  = 4,
   parameter int          N_SPRITES    = 2,
   parameter int          MAZE_COLS    = 64,
   parameter int          MAZE_ROWS    = 29,
   parameter int          BAR_BROW     = 29,
   parameter int          ROM_LAT      = 1,
   parameter int          BLINK_FRAMES = 30,
   parameter logic [11:0] KEY_COLOR    = 12'hF0F
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_pix_valid,
   input  logic [9:0]               i_col,
   input  logic [9:0]               i_row,
   input  logic                     i_frame_start,
   input  logic [6*N_SPRITES-1:0]   i_spr_bcol,
   input  logic [6*N_SPRITES-1:0]   i_spr_brow,
   input  logic [N_SPRITES-1:0]     i_spr_en,
   input  logic [N_SPRITES-1:0]     i_spr_blink,
   input  logic [5:0]               i_bar_level,
   vga_frame_layers_if.master       rom,
   output logic                     o_pix_valid,
   output logic [3:0]               o_red,
   output logic [3:0]               o_green,
   output logic [3:0]               o_blue
);
   localparam int MAZE_AW = $clog2(MAZE_COLS*MAZE_ROWS);
   localparam int IDX_W   = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
   localparam int CNT_W   = $clog2(BLINK_FRAMES);

   typedef enum logic [1:0] {
      TAG_NOTHING = 2'd0,
      TAG_BAR     = 2'd1,
      TAG_BLACK   = 2'd2,
      TAG_LAYER   = 2'd3
   } tag_t;

   logic [9:0]             bcol, brow;
   logic [BLOCK_SHIFT-1:0] lc, lr;
   tag_t                   tag_s0;
   logic                   hit_s0;
   logic [IDX_W-1:0]       hit_idx_s0;
   logic [31:0]            maze_addr_full;

   tag_t             tag_d     [ROM_LAT];
   tag_t             tag_q     [ROM_LAT];
   logic             hit_d     [ROM_LAT];
   logic             hit_q     [ROM_LAT];
   logic [IDX_W-1:0] hit_idx_d [ROM_LAT];
   logic [IDX_W-1:0] hit_idx_q [ROM_LAT];
   logic [9:0]       bcol_d    [ROM_LAT];
   logic [9:0]       bcol_q    [ROM_LAT];

   logic [CNT_W-1:0] blink_cnt_d, blink_cnt_q;
   logic             blink_phase_d, blink_phase_q;
   logic [11:0]      rgb_d, rgb_q;
   logic             pix_valid_d, pix_valid_q;
   logic [11:0]      maze_rgb, spr_rgb;
   logic             unused_rom;

   always_comb begin
      bcol = i_col >> BLOCK_SHIFT;
      brow = i_row >> BLOCK_SHIFT;
      lc   = i_col[BLOCK_SHIFT-1:0];
      lr   = i_row[BLOCK_SHIFT-1:0];

      if (!i_pix_valid)                  tag_s0 = TAG_NOTHING;
      else if (brow == 10'(BAR_BROW))    tag_s0 = TAG_BAR;
      else if (brow >= 10'(MAZE_ROWS))   tag_s0 = TAG_BLACK;
      else                               tag_s0 = TAG_LAYER;

      // Scan high to low so the lowest visible channel is the one left standing.
      hit_s0     = 1'b0;
      hit_idx_s0 = '0;
      for (int k = N_SPRITES-1; k >= 0; k--) begin
         if (tag_s0 == TAG_LAYER && i_spr_en[k] &&
             bcol == 10'(i_spr_bcol[6*k +: 6]) &&
             brow == 10'(i_spr_brow[6*k +: 6]) &&
             !(i_spr_blink[k] && blink_phase_q)) begin
            hit_s0     = 1'b1;
            hit_idx_s0 = IDX_W'(k);
         end
      end

      maze_addr_full = (tag_s0 == TAG_LAYER)
                     ? 32'(brow) * 32'(MAZE_COLS) + 32'(bcol) : 32'd0;
      rom.o_maze_addr = maze_addr_full[MAZE_AW-1:0];
      rom.o_maze_en   = rst && (tag_s0 == TAG_LAYER);
      rom.o_spr_addr  = {N_SPRITES{lr, lc}};
      rom.o_spr_en    = '0;
      rom.o_spr_en[hit_idx_s0] = rst && hit_s0;
   end

   always_comb begin
      tag_d[0]     = tag_s0;
      hit_d[0]     = hit_s0;
      hit_idx_d[0] = hit_idx_s0;
      bcol_d[0]    = bcol;
      for (int i = 1; i < ROM_LAT; i++) begin
         tag_d[i]     = tag_q[i-1];
         hit_d[i]     = hit_q[i-1];
         hit_idx_d[i] = hit_idx_q[i-1];
         bcol_d[i]    = bcol_q[i-1];
      end
   end

   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (i_frame_start) begin
         if (blink_cnt_q == CNT_W'(BLINK_FRAMES-1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      maze_rgb = rom.i_maze_data[15:4];
      spr_rgb  = '0;
      for (int k = 0; k < N_SPRITES; k++) begin
         if (hit_idx_q[ROM_LAT-1] == IDX_W'(k)) spr_rgb = rom.i_spr_data[16*k+4 +: 12];
      end

      rgb_d = '0;
      case (tag_q[ROM_LAT-1])
         TAG_BAR:   rgb_d = (bcol_q[ROM_LAT-1] < 10'(i_bar_level)) ? 12'hF00 : 12'h314;
         // A keyed pixel of the winning sprite reveals the maze, never a lower sprite.
         TAG_LAYER: rgb_d = (hit_q[ROM_LAT-1] && spr_rgb != KEY_COLOR) ? spr_rgb : maze_rgb;
         default:   rgb_d = '0;
      endcase
      pix_valid_d = (tag_q[ROM_LAT-1] != TAG_NOTHING);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < ROM_LAT; i++) begin
            tag_q[i]     <= TAG_NOTHING;
            hit_q[i]     <= 1'b0;
            hit_idx_q[i] <= '0;
            bcol_q[i]    <= '0;
         end
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         rgb_q         <= '0;
         pix_valid_q   <= 1'b0;
      end else begin
         for (int i = 0; i < ROM_LAT; i++) begin
            tag_q[i]     <= tag_d[i];
            hit_q[i]     <= hit_d[i];
            hit_idx_q[i] <= hit_idx_d[i];
            bcol_q[i]    <= bcol_d[i];
         end
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         rgb_q         <= rgb_d;
         pix_valid_q   <= pix_valid_d;
      end
   end

   assign unused_rom  = ^{rom.i_maze_data[3:0], rom.i_spr_data};
   assign o_pix_valid = pix_valid_q;
   assign o_red       = rgb_q[11:8];
   assign o_green     = rgb_q[7:4];
   assign o_blue      = rgb_q[3:0];
endmodule
`default_nettype wire

// File: tb/tb_vga_frame_layers.sv
`default_nettype none
// tb_vga_frame_layers : scoreboard bench driving a ROM_LAT=1 and a ROM_LAT=3 build in lockstep
module tb_vga_frame_layers;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam int BF    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_valid, frame_start;
   logic [9:0]  col, row;
   logic [11:0] spr_bcol, spr_brow;
   logic [1:0]  spr_en, spr_blink;
   logic [5:0]  bar_level;
   logic        pv_a, pv_b;
   logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int m_cnt;
   logic m_phase;

   typedef struct { int due; logic [12:0] px; } exp_t;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_frame_layers_if #(.N_SPRITES(2), .BLOCK_SHIFT(4), .MAZE_AW(11)) rom_a ();
   vga_frame_layers_if #(.N_SPRITES(2), .BLOCK_SHIFT(4), .MAZE_AW(11)) rom_b ();

   vga_frame_layers #(.ROM_LAT(LAT_A), .BLINK_FRAMES(BF)) dut_a (
      .clk(clk), .rst(rst), .i_pix_valid(pix_valid), .i_col(col), .i_row(row),
      .i_frame_start(frame_start), .i_spr_bcol(spr_bcol), .i_spr_brow(spr_brow),
      .i_spr_en(spr_en), .i_spr_blink(spr_blink), .i_bar_level(bar_level), .rom(rom_a),
      .o_pix_valid(pv_a), .o_red(red_a), .o_green(green_a), .o_blue(blue_a));

   vga_frame_layers #(.ROM_LAT(LAT_B), .BLINK_FRAMES(BF)) dut_b (
      .clk(clk), .rst(rst), .i_pix_valid(pix_valid), .i_col(col), .i_row(row),
      .i_frame_start(frame_start), .i_spr_bcol(spr_bcol), .i_spr_brow(spr_brow),
      .i_spr_en(spr_en), .i_spr_blink(spr_blink), .i_bar_level(bar_level), .rom(rom_b),
      .o_pix_valid(pv_b), .o_red(red_b), .o_green(green_b), .o_blue(blue_b));

   function automatic logic [15:0] maze_word(input logic [10:0] a);
      if (a == 11'd131) return 16'h1230;
      return {1'b0, a ^ 11'h5A3, 4'h0};
   endfunction

   function automatic logic [15:0] spr_word(input int k, input logic [7:0] a);
      if (k == 0) begin
         if (a == 8'd0) return 16'hF0F0;
         return {4'h7, a[7:4] ^ 4'hF, a[3:0] ^ 4'h7, 4'h0};
      end
      return {4'hC, a, 4'h0};
   endfunction

   function automatic logic [47:0] rom_read(input logic men, input logic [10:0] ma,
                                            input logic [1:0] sen, input logic [15:0] sa);
      logic [15:0] m, s0, s1;
      m  = men    ? maze_word(ma)           : 16'hDEA0;
      s0 = sen[0] ? spr_word(0, sa[7:0])    : 16'hDEA0;
      s1 = sen[1] ? spr_word(1, sa[15:8])   : 16'hDEA0;
      return {s1, s0, m};
   endfunction

   logic [47:0] pa;
   logic [47:0] pb [3];
   always @(posedge clk) begin
      pa    <= rom_read(rom_a.o_maze_en, rom_a.o_maze_addr, rom_a.o_spr_en, rom_a.o_spr_addr);
      pb[0] <= rom_read(rom_b.o_maze_en, rom_b.o_maze_addr, rom_b.o_spr_en, rom_b.o_spr_addr);
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign rom_a.i_maze_data = pa[15:0];
   assign rom_a.i_spr_data  = pa[47:16];
   assign rom_b.i_maze_data = pb[2][15:0];
   assign rom_b.i_spr_data  = pb[2][47:16];

   function automatic logic [12:0] model_px(input logic v, input int c, input int r);
      int bc, br, lc, lr, hit;
      logic [15:0] mw, sw;
      bc = c / 16; br = r / 16; lc = c % 16; lr = r % 16;
      if (!v) return 13'h0;
      if (br == 29) return {1'b1, (bc < int'(bar_level)) ? 12'hF00 : 12'h314};
      if (br > 29) return {1'b1, 12'h000};
      hit = -1;
      for (int k = 1; k >= 0; k--)
         if (spr_en[k] && spr_bcol[6*k +: 6] == 6'(bc) && spr_brow[6*k +: 6] == 6'(br) &&
             !(spr_blink[k] && m_phase)) hit = k;
      mw = maze_word(11'(br*64 + bc));
      if (hit < 0) return {1'b1, mw[15:4]};
      sw = spr_word(hit, 8'(lr*16 + lc));
      if (sw[15:4] == 12'hF0F) return {1'b1, mw[15:4]};
      return {1'b1, sw[15:4]};
   endfunction

   task automatic drive(input logic rn, input logic v, input int c, input int r, input logic fs);
      logic [12:0] px;
      exp_t e;
      @(posedge clk); #1;
      rst = rn; pix_valid = v; col = 10'(c); row = 10'(r); frame_start = fs;
      if (!rn) begin
         for (int i = 0; i < qa.size(); i++) if (qa[i].due > cyc) qa[i].px = '0;
         for (int i = 0; i < qb.size(); i++) if (qb[i].due > cyc) qb[i].px = '0;
         m_cnt = 0; m_phase = 1'b0; px = '0;
      end else begin
         px = model_px(v, c, r);
         if (fs) begin
            if (m_cnt == BF-1) begin m_cnt = 0; m_phase = ~m_phase; end
            else m_cnt++;
         end
      end
      e.px = px;
      e.due = cyc + LAT_A + 1; qa.push_back(e);
      e.due = cyc + LAT_B + 1; qb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1, 1'b0, 0, 0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (qa.size() > 0 && qa[0].due <= cyc) begin
         ea = qa.pop_front(); n_tests++;
         if ({pv_a, red_a, green_a, blue_a} !== ea.px) begin
            n_fail++;
            $display("FAIL pix_lat1 cyc=%0d got=%h exp=%h", cyc, {pv_a, red_a, green_a, blue_a}, ea.px);
         end
      end
      if (qb.size() > 0 && qb[0].due <= cyc) begin
         eb = qb.pop_front(); n_tests++;
         if ({pv_b, red_b, green_b, blue_b} !== eb.px) begin
            n_fail++;
            $display("FAIL pix_lat3 cyc=%0d got=%h exp=%h", cyc, {pv_b, red_b, green_b, blue_b}, eb.px);
         end
      end
   end

   task automatic test_reset();
      spr_bcol = {6'd10, 6'd3}; spr_brow = {6'd10, 6'd2}; spr_en = 2'b11; spr_blink = 2'b00;
      repeat (3) drive(1'b0, 1'b1, 50, 37, 1'b0);
      #1;
      n_tests++;
      if ({pv_a, red_a, green_a, blue_a, pv_b, red_b, green_b, blue_b} !== 26'h0) begin
         n_fail++; $display("FAIL reset_out got=%h exp=0", {pv_a, red_a, green_a, blue_a, pv_b, red_b, green_b, blue_b});
      end
      n_tests++;
      if ({rom_a.o_maze_en, rom_a.o_spr_en, rom_b.o_maze_en, rom_b.o_spr_en} !== 6'h0) begin
         n_fail++; $display("FAIL reset_en got=%b exp=0", {rom_a.o_maze_en, rom_a.o_spr_en, rom_b.o_maze_en, rom_b.o_spr_en});
      end
      drive(1'b1, 1'b1, 50, 37, 1'b0);
      idle(5);
   endtask

   task automatic test_sprite_hit();
      drive(1'b1, 1'b1, 50, 37, 1'b0); #1;
      n_tests++;
      if ({rom_a.o_spr_en, rom_a.o_spr_addr[7:0], rom_a.o_maze_en, rom_a.o_maze_addr} !== {2'b01, 8'd82, 1'b1, 11'd131}) begin
         n_fail++; $display("FAIL hit_rom got=%b/%0d/%b/%0d exp=01/82/1/131",
                            rom_a.o_spr_en, rom_a.o_spr_addr[7:0], rom_a.o_maze_en, rom_a.o_maze_addr);
      end
      drive(1'b1, 1'b1, 48, 32, 1'b0);
      drive(1'b1, 1'b1, 165, 170, 1'b0); #1;
      n_tests++;
      if ({pv_a, red_a, green_a, blue_a} !== 13'h17A5) begin
         n_fail++; $display("FAIL hit_rgb got=%h exp=17a5", {pv_a, red_a, green_a, blue_a});
      end
      n_tests++;
      if (rom_b.o_spr_en !== 2'b10) begin
         n_fail++; $display("FAIL hit_spr1_en got=%b exp=10", rom_b.o_spr_en);
      end
      drive(1'b1, 1'b1, 0, 0, 1'b0);
      drive(1'b1, 1'b1, 639, 463, 1'b0);
      idle(5);
   endtask

   task automatic test_overlap();
      spr_bcol = {6'd3, 6'd3}; spr_brow = {6'd2, 6'd2};
      drive(1'b1, 1'b1, 50, 37, 1'b0); #1;
      n_tests++;
      if ({rom_a.o_spr_en, rom_b.o_spr_en} !== 4'b0101) begin
         n_fail++; $display("FAIL overlap_en got=%b exp=0101", {rom_a.o_spr_en, rom_b.o_spr_en});
      end
      drive(1'b1, 1'b1, 48, 32, 1'b0);
      idle(1); idle(1); #1;
      n_tests++;
      if ({pv_a, red_a, green_a, blue_a} !== 13'h1123) begin
         n_fail++; $display("FAIL overlap_key got=%h exp=1123", {pv_a, red_a, green_a, blue_a});
      end
      idle(5);
   endtask

   task automatic test_bar();
      bar_level = 6'd5;
      drive(1'b1, 1'b1, 79, 470, 1'b0); #1;
      n_tests++;
      if ({rom_a.o_maze_en, rom_a.o_spr_en} !== 3'b000) begin
         n_fail++; $display("FAIL bar_en got=%b exp=000", {rom_a.o_maze_en, rom_a.o_spr_en});
      end
      drive(1'b1, 1'b1, 80, 470, 1'b0);
      drive(1'b1, 1'b1, 0, 470, 1'b0); #1;
      n_tests++;
      if ({pv_a, red_a, green_a, blue_a} !== 13'h1F00) begin
         n_fail++; $display("FAIL bar_col79 got=%h exp=1f00", {pv_a, red_a, green_a, blue_a});
      end
      drive(1'b1, 1'b1, 639, 470, 1'b0); #1;
      n_tests++;
      if ({pv_a, red_a, green_a, blue_a} !== 13'h1314) begin
         n_fail++; $display("FAIL bar_col80 got=%h exp=1314", {pv_a, red_a, green_a, blue_a});
      end
      drive(1'b1, 1'b1, 100, 500, 1'b0);
      idle(5);
      bar_level = 6'd63;
      drive(1'b1, 1'b1, 79, 470, 1'b0);
      drive(1'b1, 1'b1, 80, 470, 1'b0);
      drive(1'b1, 1'b1, 639, 470, 1'b0);
      idle(5);
   endtask

   task automatic test_blink();
      spr_bcol = {6'd10, 6'd3}; spr_brow = {6'd10, 6'd2}; spr_blink = 2'b01;
      drive(1'b1, 1'b1, 50, 37, 1'b0);
      drive(1'b1, 1'b1, 50, 37, 1'b1);
      drive(1'b1, 1'b1, 50, 37, 1'b1); #1;
      n_tests++;
      if (rom_a.o_spr_en !== 2'b01) begin
         n_fail++; $display("FAIL blink_old_phase got=%b exp=01", rom_a.o_spr_en);
      end
      drive(1'b1, 1'b1, 50, 37, 1'b0); #1;
      n_tests++;
      if ({rom_a.o_spr_en, rom_b.o_spr_en} !== 4'b0000) begin
         n_fail++; $display("FAIL blink_hidden got=%b exp=0000", {rom_a.o_spr_en, rom_b.o_spr_en});
      end
      drive(1'b1, 1'b1, 48, 33, 1'b1);
      drive(1'b1, 1'b1, 50, 37, 1'b1);
      drive(1'b1, 1'b1, 50, 37, 1'b0); #1;
      n_tests++;
      if (rom_a.o_spr_en !== 2'b01) begin
         n_fail++; $display("FAIL blink_back got=%b exp=01", rom_a.o_spr_en);
      end
      idle(5);
   endtask

   task automatic test_back_to_back();
      int start, lat_a, lat_b;
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 40 + i*13, 30 + i*7, 1'b0);
      idle(5);
      drive(1'b1, 1'b1, 50, 37, 1'b0);
      start = cyc; lat_a = -1; lat_b = -1;
      for (int i = 0; i < 8; i++) begin
         idle(1);
         @(negedge clk);
         if (pv_a === 1'b1 && lat_a < 0) lat_a = cyc - start;
         if (pv_b === 1'b1 && lat_b < 0) lat_b = cyc - start;
      end
      n_tests++;
      if (lat_a != LAT_A + 1 || lat_b != LAT_B + 1) begin
         n_fail++; $display("FAIL latency got=%0d/%0d exp=%0d/%0d", lat_a, lat_b, LAT_A + 1, LAT_B + 1);
      end
      idle(3);
   endtask

   task automatic test_reset_mid_burst();
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 30 + i*17, 20 + i*11, 1'b0);
      drive(1'b0, 1'b1, 50, 37, 1'b0);
      drive(1'b0, 1'b1, 51, 37, 1'b0); #1;
      n_tests++;
      if ({pv_a, red_a, green_a, blue_a, pv_b, red_b, green_b, blue_b} !== 26'h0) begin
         n_fail++; $display("FAIL midrst_out got=%h exp=0", {pv_a, red_a, green_a, blue_a, pv_b, red_b, green_b, blue_b});
      end
      idle(6);
   endtask

   task automatic test_idle();
      drive(1'b1, 1'b0, 50, 37, 1'b0); #1;
      n_tests++;
      if ({rom_a.o_maze_en, rom_a.o_spr_en, rom_b.o_maze_en, rom_b.o_spr_en} !== 6'h0) begin
         n_fail++; $display("FAIL idle_en got=%b exp=0", {rom_a.o_maze_en, rom_a.o_spr_en, rom_b.o_maze_en, rom_b.o_spr_en});
      end
      drive(1'b1, 1'b0, 48, 470, 1'b0);
      idle(5);
   endtask

   initial begin
      rst = 1'b0; pix_valid = 1'b0; col = '0; row = '0; frame_start = 1'b0;
      spr_bcol = '0; spr_brow = '0; spr_en = '0; spr_blink = '0; bar_level = '0;
      m_cnt = 0; m_phase = 1'b0;
      test_reset();
      test_sprite_hit();
      test_overlap();
      test_bar();
      test_blink();
      test_back_to_back();
      test_reset_mid_burst();
      test_idle();
      repeat (6) @(negedge clk);
      n_tests++;
      if (qa.size() + qb.size() != 0) begin
         n_fail++; $display("FAIL drain got=%0d exp=0", qa.size() + qb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
